// File: rtl/axi4_mem_master_bridge.sv
// rtl/axi4_mem_master_bridge.sv - single-beat CPU request to AXI4 master bridge
// Optional handshake timeout enabled by defining AXI4_BRIDGE_TIMEOUT_EN.
module axi4_mem_master_bridge #(
   parameter int AXI4_ID_WIDTH = 4,
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int TXN_ID        = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cpu_req_valid,
   output logic                       cpu_req_ready,
   input  logic                       cpu_req_we,
   input  logic [ADDR_WIDTH-1:0]      cpu_req_addr,
   input  logic [DATA_WIDTH-1:0]      cpu_req_wdata,
   input  logic [DATA_WIDTH/8-1:0]    cpu_req_wstrb,
   output logic                       cpu_rsp_valid,
   output logic [DATA_WIDTH-1:0]      cpu_rsp_rdata,
   output logic                       cpu_rsp_err,
   output logic [AXI4_ID_WIDTH-1:0]   m2_axi4_awid,
   output logic [ADDR_WIDTH-1:0]      m2_axi4_awaddr,
   output logic [7:0]                 m2_axi4_awlen,
   output logic [2:0]                 m2_axi4_awsize,
   output logic [1:0]                 m2_axi4_awburst,
   output logic                       m2_axi4_awvalid,
   input  logic                       m2_axi4_awready,
   output logic [DATA_WIDTH-1:0]      m2_axi4_wdata,
   output logic [DATA_WIDTH/8-1:0]    m2_axi4_wstrb,
   output logic                       m2_axi4_wlast,
   output logic                       m2_axi4_wvalid,
   input  logic                       m2_axi4_wready,
   input  logic [AXI4_ID_WIDTH-1:0]   m2_axi4_bid,
   input  logic [1:0]                 m2_axi4_bresp,
   input  logic                       m2_axi4_bvalid,
   output logic                       m2_axi4_bready,
   output logic [AXI4_ID_WIDTH-1:0]   m2_axi4_arid,
   output logic [ADDR_WIDTH-1:0]      m2_axi4_araddr,
   output logic [7:0]                 m2_axi4_arlen,
   output logic [2:0]                 m2_axi4_arsize,
   output logic [1:0]                 m2_axi4_arburst,
   output logic                       m2_axi4_arvalid,
   input  logic                       m2_axi4_arready,
   input  logic [AXI4_ID_WIDTH-1:0]   m2_axi4_rid,
   input  logic [DATA_WIDTH-1:0]      m2_axi4_rdata,
   input  logic [1:0]                 m2_axi4_rresp,
   input  logic                       m2_axi4_rlast,
   input  logic                       m2_axi4_rvalid,
   output logic                       m2_axi4_rready
);

   localparam logic [AXI4_ID_WIDTH-1:0] ID = AXI4_ID_WIDTH'(TXN_ID);

   typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE} state_t;

   state_t                    state, state_next;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH/8-1:0]   wstrb_q;
   logic [DATA_WIDTH-1:0]     data_q;
   logic                      first_q;
   logic                      accept;
   logic                      tmo;
   logic                      rsp_load;
   logic [DATA_WIDTH-1:0]     rsp_rdata_n;
   logic                      rsp_err_n;
   logic                      aw_phase, ar_phase;
   logic                      unused_bits;

   assign unused_bits = ^{m2_axi4_bresp[0], m2_axi4_rresp[0]};

`ifdef AXI4_BRIDGE_TIMEOUT_EN
   logic [7:0] tmo_cnt;
   logic       busy;

   assign busy = (state == WADDR) || (state == WDATA) || (state == WRESP) ||
                 (state == RADDR) || (state == RDATA);

   // Restarts on every state change, so each handshake gets its own 255-cycle budget.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tmo_cnt <= 8'd0;
      else if (state_next != state)
         tmo_cnt <= 8'd0;
      else if (busy)
         tmo_cnt <= tmo_cnt + 8'd1;
   end

   assign tmo = busy && (tmo_cnt == 8'hFF);
`else
   assign tmo = 1'b0;
`endif

   assign cpu_req_ready = (state == IDLE) && !rst;
   assign accept        = cpu_req_valid && cpu_req_ready;
   assign cpu_rsp_valid = (state == DONE);

   assign aw_phase        = (state == WADDR);
   assign m2_axi4_awvalid = aw_phase && !tmo;
   assign m2_axi4_awid    = aw_phase ? ID : '0;
   assign m2_axi4_awaddr  = addr_q;
   assign m2_axi4_awlen   = 8'd0;
   assign m2_axi4_awsize  = aw_phase ? 3'b010 : 3'b000;
   assign m2_axi4_awburst = aw_phase ? 2'b01 : 2'b00;

   assign m2_axi4_wdata   = wdata_q;
   assign m2_axi4_wstrb   = wstrb_q;
   assign m2_axi4_wlast   = (state == WDATA);
   assign m2_axi4_wvalid  = (state == WDATA) && !tmo;
   assign m2_axi4_bready  = (state == WRESP) && !tmo;

   assign ar_phase        = (state == RADDR);
   assign m2_axi4_arvalid = ar_phase && !tmo;
   assign m2_axi4_arid    = ar_phase ? ID : '0;
   assign m2_axi4_araddr  = addr_q;
   assign m2_axi4_arlen   = 8'd0;
   assign m2_axi4_arsize  = ar_phase ? 3'b010 : 3'b000;
   assign m2_axi4_arburst = ar_phase ? 2'b01 : 2'b00;
   assign m2_axi4_rready  = (state == RDATA) && !tmo;

   always_comb begin
      state_next  = state;
      rsp_load    = 1'b0;
      rsp_rdata_n = '0;
      rsp_err_n   = 1'b0;
      if (tmo) begin
         state_next = DONE;
         rsp_load   = 1'b1;
         rsp_err_n  = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (cpu_req_addr[1:0] != 2'b00) begin
                     state_next = DONE;
                     rsp_load   = 1'b1;
                     rsp_err_n  = 1'b1;
                  end else if (cpu_req_we) begin
                     state_next = WADDR;
                  end else begin
                     state_next = RADDR;
                  end
               end
            end
            WADDR: if (m2_axi4_awready) state_next = WDATA;
            WDATA: if (m2_axi4_wready) state_next = WRESP;
            WRESP: begin
               if (m2_axi4_bvalid) begin
                  state_next = DONE;
                  rsp_load   = 1'b1;
                  rsp_err_n  = m2_axi4_bresp[1] | (m2_axi4_bid != ID);
               end
            end
            RADDR: if (m2_axi4_arready) state_next = RDATA;
            RDATA: begin
               // A multi-beat reply is a protocol error, but the first beat's data is still returned.
               if (m2_axi4_rvalid && m2_axi4_rlast) begin
                  state_next  = DONE;
                  rsp_load    = 1'b1;
                  rsp_rdata_n = first_q ? m2_axi4_rdata : data_q;
                  rsp_err_n   = first_q ? (m2_axi4_rresp[1] | (m2_axi4_rid != ID)) : 1'b1;
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         data_q        <= '0;
         first_q       <= 1'b0;
         cpu_rsp_rdata <= '0;
         cpu_rsp_err   <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            addr_q  <= cpu_req_addr;
            wdata_q <= cpu_req_wdata;
            wstrb_q <= cpu_req_wstrb;
            first_q <= 1'b1;
         end
         if (m2_axi4_rvalid && m2_axi4_rready) begin
            first_q <= 1'b0;
            if (first_q)
               data_q <= m2_axi4_rdata;
         end
         // Response registers only move when DONE is entered, so they hold between pulses.
         if (rsp_load) begin
            cpu_rsp_rdata <= rsp_rdata_n;
            cpu_rsp_err   <= rsp_err_n;
         end
      end
   end

endmodule

// File: tb/tb_axi4_mem_master_bridge.sv
// tb/tb_axi4_mem_master_bridge.sv - scoreboard bench for axi4_mem_master_bridge
module tb_axi4_mem_master_bridge;

   localparam int IDW = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TID = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            cpu_req_valid = 1'b0;
   logic            cpu_req_ready;
   logic            cpu_req_we = 1'b0;
   logic [AW-1:0]   cpu_req_addr = '0;
   logic [DW-1:0]   cpu_req_wdata = '0;
   logic [DW/8-1:0] cpu_req_wstrb = '0;
   logic            cpu_rsp_valid;
   logic [DW-1:0]   cpu_rsp_rdata;
   logic            cpu_rsp_err;
   logic [IDW-1:0]  awid, arid, bid, rid;
   logic [AW-1:0]   awaddr, araddr;
   logic [7:0]      awlen, arlen;
   logic [2:0]      awsize, arsize;
   logic [1:0]      awburst, arburst, bresp, rresp;
   logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic            arvalid, arready, rlast, rvalid, rready;
   logic [DW-1:0]   wdata, rdata;
   logic [DW/8-1:0] wstrb;

   axi4_mem_master_bridge #(
      .AXI4_ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TXN_ID(TID)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
      .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
      .m2_axi4_awid(awid), .m2_axi4_awaddr(awaddr), .m2_axi4_awlen(awlen), .m2_axi4_awsize(awsize),
      .m2_axi4_awburst(awburst), .m2_axi4_awvalid(awvalid), .m2_axi4_awready(awready),
      .m2_axi4_wdata(wdata), .m2_axi4_wstrb(wstrb), .m2_axi4_wlast(wlast), .m2_axi4_wvalid(wvalid),
      .m2_axi4_wready(wready),
      .m2_axi4_bid(bid), .m2_axi4_bresp(bresp), .m2_axi4_bvalid(bvalid), .m2_axi4_bready(bready),
      .m2_axi4_arid(arid), .m2_axi4_araddr(araddr), .m2_axi4_arlen(arlen), .m2_axi4_arsize(arsize),
      .m2_axi4_arburst(arburst), .m2_axi4_arvalid(arvalid), .m2_axi4_arready(arready),
      .m2_axi4_rid(rid), .m2_axi4_rdata(rdata), .m2_axi4_rresp(rresp), .m2_axi4_rlast(rlast),
      .m2_axi4_rvalid(rvalid), .m2_axi4_rready(rready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            lat;
      int            acc;
   } exp_t;
   exp_t sbq[$];

   // slave behaviour knobs
   int             aw_delay = 0;
   logic [1:0]     b_resp_cfg = 2'b00;
   logic [IDW-1:0] b_id_cfg = IDW'(TID);
   logic           ar_en = 1'b1;
   int             r_beats = 1;
   logic [DW-1:0]  r_base = '0;
   logic [1:0]     r_resp_cfg = 2'b00;
   logic [IDW-1:0] r_id_cfg = IDW'(TID);
   logic           no_bus = 1'b0;
   logic [AW-1:0]  exp_addr = '0;
   logic [DW-1:0]  exp_wdata = '0;
   logic [3:0]     exp_strb = '0;
   int             aw_cycles = 0;
   int             ar_cycles = 0;

   int             aw_cnt = 0;
   logic           aw_done = 1'b0;
   logic           b_pend = 1'b0;
   int             r_left = 0;
   int             r_idx = 0;

   assign arready = arvalid && ar_en;

   // AXI slave model and response monitor, evaluated on the falling edge
   initial begin
      awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
      rvalid = 0; rlast = 0; rdata = '0; rid = '0; rresp = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            awready = 0; wready = 0; bvalid = 0; rvalid = 0; rlast = 0;
            b_pend = 0; r_left = 0; aw_done = 0; aw_cnt = 0;
         end else begin
            if (no_bus) begin
               checks++;
               if (awvalid || arvalid || wvalid) begin
                  errors++;
                  $display("FAIL no_bus got aw=%b ar=%b w=%b want 0", awvalid, arvalid, wvalid);
               end
            end
            bvalid = b_pend; bresp = b_resp_cfg; bid = b_id_cfg;
            if (bvalid && bready) b_pend = 0;
            if (wvalid) begin
               checks++;
               if (!aw_done || wlast !== 1'b1 || wdata !== exp_wdata || wstrb !== exp_strb) begin
                  errors++;
                  $display("FAIL w_beat got awdone=%b last=%b data=%h strb=%h want 1 1 %h %h",
                           aw_done, wlast, wdata, wstrb, exp_wdata, exp_strb);
               end
               wready = 1; b_pend = 1; aw_done = 0;
            end else begin
               wready = 0;
            end
            if (awvalid) begin
               checks++;
               if ({awaddr, awlen, awsize, awburst, awid} !== {exp_addr, 8'd0, 3'b010, 2'b01, IDW'(TID)}) begin
                  errors++;
                  $display("FAIL aw_payload got %h %h %h %h %h want %h 0 2 1 %h",
                           awaddr, awlen, awsize, awburst, awid, exp_addr, TID);
               end
               aw_cycles++;
               awready = (aw_cnt >= aw_delay);
               aw_cnt++;
               if (awready) aw_done = 1;
            end else begin
               awready = 0; aw_cnt = 0;
            end
            rvalid = (r_left > 0); rlast = (r_left == 1);
            rdata = r_base + DW'(r_idx); rresp = r_resp_cfg; rid = r_id_cfg;
            if (rvalid && rready) begin r_left--; r_idx++; end
            if (arvalid) begin
               checks++;
               if ({araddr, arlen, arsize, arburst, arid} !== {exp_addr, 8'd0, 3'b010, 2'b01, IDW'(TID)}) begin
                  errors++;
                  $display("FAIL ar_payload got %h %h %h %h %h want %h 0 2 1 %h",
                           araddr, arlen, arsize, arburst, arid, exp_addr, TID);
               end
               ar_cycles++;
               if (arready) begin r_left = r_beats; r_idx = 0; end
            end
            if (cpu_rsp_valid) begin
               checks++;
               if (sbq.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_rsp got rsp_valid=1 want 0");
               end else begin
                  exp_t e;
                  e = sbq.pop_front();
                  checks += 3;
                  if (cpu_rsp_rdata !== e.rdata) begin
                     errors++;
                     $display("FAIL rsp_rdata got %h want %h", cpu_rsp_rdata, e.rdata);
                  end
                  if (cpu_rsp_err !== e.err) begin
                     errors++;
                     $display("FAIL rsp_err got %b want %b", cpu_rsp_err, e.err);
                  end
                  if (cyc - e.acc + 1 !== e.lat) begin
                     errors++;
                     $display("FAIL rsp_latency got %0d want %0d", cyc - e.acc + 1, e.lat);
                  end
               end
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] s, input logic [DW-1:0] er, input logic ee,
                        input int el, input bit push);
      int n = 0;
      @(negedge clk);
      exp_addr = a; exp_wdata = d; exp_strb = s;
      cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = d; cpu_req_wstrb = s;
      while (!cpu_req_ready && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (!cpu_req_ready) begin
         errors++;
         $display("FAIL req_accept got ready=0 want 1");
      end else if (push) begin
         sbq.push_back('{er, ee, el, cyc});
      end
      @(negedge clk);
      cpu_req_valid = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sbq.size() != 0 || !cpu_req_ready) && n < 2000) begin @(negedge clk); n++; end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL rsp_timeout got pending=%0d want 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 3;
      if ({awvalid, wvalid, bready, arvalid, rready, cpu_rsp_valid, cpu_req_ready} !== 7'b0) begin
         errors++;
         $display("FAIL reset_handshake got %b want 0",
                  {awvalid, wvalid, bready, arvalid, rready, cpu_rsp_valid, cpu_req_ready});
      end
      if ({awaddr, awid, awsize, awburst, araddr, arid, arsize, arburst, wdata, wstrb} !== '0) begin
         errors++;
         $display("FAIL reset_payload got nonzero want 0");
      end
      if ({cpu_rsp_rdata, cpu_rsp_err} !== '0) begin
         errors++;
         $display("FAIL reset_rsp got %h %b want 0 0", cpu_rsp_rdata, cpu_rsp_err);
      end
      rst = 0;
      @(negedge clk);
      checks++;
      if (cpu_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", cpu_req_ready);
      end
   endtask

   task automatic test_write_basic();
      aw_delay = 0; b_resp_cfg = 2'b00; b_id_cfg = IDW'(TID); aw_cycles = 0;
      issue(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, '0, 0, 5, 1);
      wait_idle();
      checks++;
      if (aw_cycles !== 1) begin
         errors++;
         $display("FAIL write_aw_cycles got %0d want 1", aw_cycles);
      end
   endtask

   task automatic test_read_basic();
      r_beats = 1; r_base = 32'hDEAD_BEEF; r_resp_cfg = 2'b00; r_id_cfg = IDW'(TID);
      issue(0, 32'h0000_0010, '0, 4'h0, 32'hDEAD_BEEF, 0, 4, 1);
      wait_idle();
   endtask

   task automatic test_misaligned();
      no_bus = 1;
      issue(0, 32'h0000_0002, '0, 4'h0, '0, 1, 2, 1);
      wait_idle();
      issue(1, 32'h0000_0103, 32'h1111_2222, 4'hF, '0, 1, 2, 1);
      wait_idle();
      no_bus = 0;
   endtask

   task automatic test_hold();
      r_beats = 1; r_base = 32'h1234_5678;
      issue(0, 32'h0000_0034, '0, 4'h0, 32'h1234_5678, 0, 4, 1);
      wait_idle();
      repeat (5) @(negedge clk);
      checks++;
      if ({cpu_rsp_rdata, cpu_rsp_err, cpu_rsp_valid} !== {32'h1234_5678, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL rsp_hold got %h %b %b want 12345678 0 0", cpu_rsp_rdata, cpu_rsp_err, cpu_rsp_valid);
      end
   endtask

   task automatic test_aw_delay();
      aw_delay = 7; b_resp_cfg = 2'b10; aw_cycles = 0;
      issue(1, 32'h0000_0020, 32'h0000_A5A5, 4'h3, '0, 1, 12, 1);
      wait_idle();
      checks++;
      if (aw_cycles !== 8) begin
         errors++;
         $display("FAIL aw_delay_cycles got %0d want 8", aw_cycles);
      end
      aw_delay = 0; b_resp_cfg = 2'b00;
   endtask

   task automatic test_id_mismatch();
      b_id_cfg = IDW'(TID ^ 1);
      issue(1, 32'h0000_0024, 32'h0BAD_F00D, 4'hF, '0, 1, 5, 1);
      wait_idle();
      b_id_cfg = IDW'(TID);
      r_id_cfg = IDW'(TID ^ 2); r_beats = 1; r_base = 32'h5555_AAAA;
      issue(0, 32'h0000_0028, '0, 4'h0, 32'h5555_AAAA, 1, 4, 1);
      wait_idle();
      r_id_cfg = IDW'(TID);
   endtask

   task automatic test_multibeat();
      r_beats = 3; r_base = 32'hCAFE_0000;
      issue(0, 32'h0000_0030, '0, 4'h0, 32'hCAFE_0000, 1, 6, 1);
      wait_idle();
      r_beats = 1;
   endtask

   task automatic test_back_to_back();
      r_beats = 1; r_base = 32'h7777_0001;
      for (int i = 0; i < 6; i++) begin
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         a = {$urandom_range(0, 1023), 2'b00};
         d = $urandom;
         if (i % 2 == 0)
            issue(1, a, d, 4'(i + 1), '0, 0, 5, 1);
         else
            issue(0, a, '0, 4'h0, 32'h7777_0001, 0, 4, 1);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid();
      aw_delay = 50;
      issue(1, 32'h0000_0040, 32'h0F0F_0F0F, 4'hF, '0, 0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      checks++;
      if ({cpu_req_ready, awvalid, wvalid} !== 3'b100) begin
         errors++;
         $display("FAIL reset_mid got ready=%b aw=%b w=%b want 1 0 0", cpu_req_ready, awvalid, wvalid);
      end
      repeat (10) @(negedge clk);
      aw_delay = 0;
   endtask

`ifdef AXI4_BRIDGE_TIMEOUT_EN
   task automatic test_timeout();
      ar_en = 0; ar_cycles = 0;
      issue(0, 32'h0000_0050, '0, 4'h0, '0, 1, 258, 1);
      wait_idle();
      checks++;
      if (ar_cycles !== 255) begin
         errors++;
         $display("FAIL timeout_ar_cycles got %0d want 255", ar_cycles);
      end
      ar_en = 1;
   endtask
`endif

   initial begin
      test_reset();
      test_write_basic();
      test_read_basic();
      test_misaligned();
      test_hold();
      test_aw_delay();
      test_id_mismatch();
      test_multibeat();
      test_back_to_back();
      test_reset_mid();
`ifdef AXI4_BRIDGE_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
